fir_sample_reader: RTL
======================

FIR_SAMPLE_READER -- requirements
Module: fir_sample_reader

Interface
REQ-001 Parameter DW, default 8: sample width, two's-complement FIR output.
REQ-002 Parameter DIV, default 16: clk cycles per sample period; legal range 2..256.
REQ-003 Parameter DEPTH, default 8: FIFO entries; power of two, 2..64.
REQ-004 Parameter WARM, default 2: samples discarded after each enable, covering filter fill; 0..15.
REQ-005 One clock; reset is asynchronous and active-low: port clk, port rst (active-low, asynchronous).
REQ-006 clk  in  1  system clock, same clock that drives the FIR.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 en  in  1  capture enable.
REQ-009 fir_dout  in  DW  FIR output sample, stable across the sample period.
REQ-010 sample_tick  out  1  one-cycle pulse on the clk edge where a sample is taken.
REQ-011 m_data  out  DW  FIFO head sample.
REQ-012 m_valid  out  1  m_data holds a valid sample.
REQ-013 m_ready  in  1  consumer accepts m_data.
REQ-014 count  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 overflow  out  1  sticky flag: a sample was dropped because the FIFO was full.
REQ-016 clr_ovf  in  1  synchronous clear of overflow.

Function
REQ-017 FSM states IDLE, WARMUP, RUN; IDLE->WARMUP when en=1; WARMUP->RUN on the WARM-th tick, or directly in the same cycle when WARM=0; any state->IDLE when en=0.
REQ-018 Sample counter: 0 in IDLE; counts 0..DIV-1 in WARMUP/RUN and wraps to 0; sample_tick=1 exactly when counter==DIV-1 and en=1.
REQ-019 First tick falls DIV cycles after the en rising edge is sampled; subsequent ticks follow every DIV cycles.
REQ-020 WARMUP: ticks are counted and fir_dout is discarded, with no FIFO write.
REQ-021 RUN: each tick writes fir_dout into the FIFO unless full.
REQ-022 Tick while full with no pop in the same cycle: sample dropped, overflow<=1, FIFO contents unchanged.
REQ-023 Tick and pop in the same cycle while full: both occur, count unchanged, overflow not set.
REQ-024 Pop occurs when m_valid && m_ready; pop while empty has no effect.
REQ-025 FIFO is first-word-fall-through: m_valid rises on the clk edge after the write edge, with m_data equal to the written sample.
REQ-026 m_data holds its value while m_valid=1 and m_ready=0.
REQ-027 Samples are delivered in capture order with no duplication.
REQ-028 clr_ovf=1 clears overflow; when clr_ovf and a drop occur in the same cycle, the drop wins (overflow=1).
REQ-029 en deasserted: counter returns to 0, FIFO contents are kept, and draining continues.
REQ-030 Re-enable always passes through WARMUP again.
REQ-031 Pointers wrap modulo DEPTH; count is the sole full/empty source (full when count==DEPTH).

Reset
REQ-032 rst=0 immediately forces state=IDLE, counter=0, FIFO pointers=0, count=0, m_valid=0, sample_tick=0, overflow=0, m_data=0.
REQ-033 Reset asserted mid-operation discards all buffered samples; after rst rises, the block waits for en as from power-up.

Structure
REQ-034 Shared package fir_pkg holds the state enum, default DW/DIV/DEPTH/WARM, and a count-width function.
REQ-035 One sub-module, fir_sample_fifo (synchronous FWFT FIFO, DW x DEPTH, push/pop/count/full/empty).
REQ-036 The FSM, sample counter and overflow logic stay in fir_sample_reader; there are no other clocks and no latches.

Verification (DIV=16, DEPTH=8, WARM=2)
REQ-037 Reset: rst=0 with en=1 and fir_dout=8'h7F -> m_valid=0, count=0, overflow=0, sample_tick=0 for the whole reset.
REQ-038 Warm-up: en=1, fir_dout=8'h05, m_ready=1 -> ticks at cycles 16, 32 and 48 after en; the first two are discarded; m_valid=1 at cycle 49 with m_data=8'h05 for one cycle.
REQ-039 Fill/overflow: m_ready=0, fir_dout=1,2,3,... changing per tick -> count reaches 8 after 8 RUN ticks; the 9th tick gives overflow=1 with count=8; draining then yields exactly 1..8.
REQ-040 Simultaneous: FIFO full and m_ready=1 on the tick cycle -> count stays 8, overflow stays 0, and the new sample appears last.
REQ-041 Enable drop: en=0 after 3 RUN samples -> no further sample_tick, the 3 samples still drain; re-enable -> next write occurs only after 2 new discarded ticks.
REQ-042 Async reset mid-run with count=5 -> count=0 and m_valid=0 before the next clk edge; clr_ovf=1 for one cycle then clears a set overflow.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types, defaults and width helper for the FIR sample reader.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  localparam int DW_DEF    = 8;
  localparam int DIV_DEF   = 16;
  localparam int DEPTH_DEF = 8;
  localparam int WARM_DEF  = 2;

  // Occupancy counter must hold the value DEPTH itself, hence the extra bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// First-word-fall-through sample FIFO; occupancy count is the only full/empty source.
module fir_sample_fifo
  import fir_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DW-1:0]           din,
  input  logic                    pop,
  output logic [DW-1:0]           dout,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_q];
  assign count   = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/fir_sample_reader.sv
// Decimates FIR output to one sample per DIV clocks, skips WARM samples after
// each enable, and buffers the rest in a FWFT FIFO with a sticky overflow flag.
module fir_sample_reader
  import fir_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DIV   = DIV_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int WARM  = WARM_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DW-1:0]           fir_dout,
  output logic                    sample_tick,
  output logic [DW-1:0]           m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    overflow,
  input  logic                    clr_ovf
);

  localparam int SW = $clog2(DIV);

  state_t        state_q, state_d;
  logic [SW-1:0] smp_q, smp_d;
  logic [3:0]    warm_q, warm_d;
  logic          ovf_q, ovf_d;
  logic          pop, push, drop, full, empty;

  assign sample_tick = en && (smp_q == SW'(DIV - 1));
  assign m_valid     = !empty;
  assign pop         = m_valid && m_ready;
  assign push        = sample_tick && (state_q == RUN);
  assign drop        = push && full && !pop;
  assign overflow    = ovf_q;

  always_comb begin
    state_d = state_q;
    smp_d   = '0;
    warm_d  = warm_q;
    if (en) begin
      case (state_q)
        IDLE: begin
          warm_d  = '0;
          state_d = (WARM == 0) ? RUN : WARMUP;
        end
        WARMUP: begin
          smp_d = sample_tick ? '0 : smp_q + SW'(1);
          // The WARM-th discarded tick is also the hand-off into RUN.
          if (sample_tick) begin
            if (warm_q == 4'(WARM - 1)) begin
              state_d = RUN;
              warm_d  = '0;
            end else begin
              warm_d = warm_q + 4'd1;
            end
          end
        end
        RUN:     smp_d = sample_tick ? '0 : smp_q + SW'(1);
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = IDLE;
      warm_d  = '0;
    end
  end

  // Drop beats clear when both land in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      smp_q   <= '0;
      warm_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      warm_q  <= warm_d;
      ovf_q   <= ovf_d;
    end
  end

  fir_sample_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fir_dout),
    .pop   (pop),
    .dout  (m_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule
